resize_frame_ctrl: RTL and testbench
====================================

Name: resize_frame_ctrl

Overview:
- Frame-level scheduler in front of the imresize bilinear downscaler.
- Admits one complete input frame at a time into the resizer and latches its in_width/in_height per frame from software shadow registers.
- Drops frames that arrive while the resizer is still busy, tracks resizer output completion, and reports done, error and statistics.
- Sits between the camera/VDMA pixel stream and imresize, in the resizer's input clock domain.

Parameters:
- OUT_X, 64, resizer output width in pixels.
- OUT_Y, 64, resizer output height in pixels.
- MAX_W, 1280, largest admissible input width.
- MAX_H, 511, largest admissible input height.
- TIMEOUT_CYC, 65536, maximum idle cycles between resizer output pixels while draining.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  admit frames when high.
- cfg_width  in  11  requested input width, sampled at frame admission.
- cfg_height  in  9  requested input height, sampled at frame admission.
- err_clr  in  1  clears sticky error flags.
- vsync_in  in  1  source vsync; rising edge marks frame start.
- de_in  in  1  source pixel valid.
- pixel_in  in  24  source RGB pixel.
- rs_vsync  out  1  vsync to resizer.
- rs_de  out  1  pixel valid to resizer.
- rs_pixel  out  24  pixel to resizer.
- rs_in_width  out  11  latched width to resizer.
- rs_in_height  out  9  latched height to resizer.
- rs_de_out  in  1  resizer output pixel valid.
- busy  out  1  high in FEED or DRAIN.
- frame_done  out  1  one-cycle pulse when an output frame completes.
- err_cfg  out  1  sticky: invalid configuration at a frame start.
- err_short  out  1  sticky: new vsync arrived before the input frame completed.
- err_timeout  out  1  sticky: drain watchdog expired.
- frames_accepted  out  16  saturating count of admitted frames.
- frames_dropped  out  16  saturating count of rejected frames.

Behaviour:
- Reset: every output is 0. State is ARM. All counters are 0. The vsync edge register is 0.
- vrise = vsync_in & ~vsync_q, where vsync_q is vsync_in registered.
- Config valid when OUT_X ≤ cfg_width ≤ MAX_W and OUT_Y ≤ cfg_height ≤ MAX_H.
- ARM:
  - On vrise with cfg_enable=1 and config valid: latch rs_in_width/rs_in_height, increment frames_accepted, clear the input and output pixel counters, go to FEED.
  - On vrise with cfg_enable=1 and config invalid: set err_cfg, increment frames_dropped, stay in ARM.
  - On vrise with cfg_enable=0: ignored, no count.
- FEED:
  - Count de_in pixels (21-bit counter). When the count reaches in_width*in_height (the multiply is computed and registered at admission), go to DRAIN.
  - On vrise before the count completes: set err_short, increment frames_dropped, go to DRAIN. That vsync is not forwarded.
- DRAIN:
  - Wait until the output pixel count equals OUT_X*OUT_Y, then go to DONE.
  - Watchdog counter resets on each rs_de_out and on DRAIN entry. If it reaches TIMEOUT_CYC: set err_timeout, go to ARM, no frame_done.
- DONE: frame_done=1 for exactly one cycle, then go to ARM.
- Any vrise in DRAIN or DONE: increment frames_dropped (FEED→DRAIN vrise counted once only).
- Output pixel counter (13-bit): counts rs_de_out in FEED and DRAIN. It saturates at OUT_X*OUT_Y; extra pixels are ignored.
- Pass-through (1-cycle registered):
  - rs_de <= de_in & (state==FEED).
  - rs_pixel <= pixel_in when FEED, else 0.
  - rs_vsync <= vsync_in when FEED or (ARM and accepting vrise), else 0.
- rs_in_width/rs_in_height hold between admissions; cfg changes mid-frame have no effect.
- err_clr clears all sticky errors; if an error sets in the same cycle, set wins.
- frames_accepted and frames_dropped saturate at 16'hFFFF.
- rst mid-frame returns to ARM immediately. rs_de/rs_vsync are 0 on the next edge; the frame in flight is neither done nor counted as dropped.

Test Plan:
- Nominal: cfg 96x96, one frame of 9216 de_in, resizer stub emits 4096 rs_de_out → rs_in_width=96, rs_in_height=96, one frame_done pulse, frames_accepted=1, busy falls the cycle after frame_done.
- Busy drop: second vrise while DRAIN waits for the last 100 output pixels → frames_dropped=1, rs_vsync stays 0, the first frame still completes.
- Bad config: cfg_width=32 at vrise → err_cfg=1, frames_dropped=1, rs_de never asserts; err_clr → err_cfg=0.
- Short frame: vrise after 5000 of 9216 pixels → err_short=1, state DRAIN. With no further rs_de_out, err_timeout=1 after TIMEOUT_CYC (set to 200 in bench) cycles, back to ARM.
- Config hold: cfg_width changed 96→128 mid-FEED → rs_in_width stays 96 until the next admission, then becomes 128.
- Reset mid-FEED: assert rst for 1 cycle at pixel 3000 → all outputs 0, next valid vrise admitted normally, frames_accepted=1.

Source files
------------

// File: rtl/resize_frame_ctrl.sv
// Frame scheduler in front of the bilinear downscaler: admits one frame at a time,
// latches its geometry, drops frames that arrive while busy, and tracks output completion.
module resize_frame_ctrl #(
   parameter int OUT_X       = 64,
   parameter int OUT_Y       = 64,
   parameter int MAX_W       = 1280,
   parameter int MAX_H       = 511,
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_enable,
   input  logic [10:0] cfg_width,
   input  logic [8:0]  cfg_height,
   input  logic        err_clr,
   input  logic        vsync_in,
   input  logic        de_in,
   input  logic [23:0] pixel_in,
   output logic        rs_vsync,
   output logic        rs_de,
   output logic [23:0] rs_pixel,
   output logic [10:0] rs_in_width,
   output logic [8:0]  rs_in_height,
   input  logic        rs_de_out,
   output logic        busy,
   output logic        frame_done,
   output logic        err_cfg,
   output logic        err_short,
   output logic        err_timeout,
   output logic [15:0] frames_accepted,
   output logic [15:0] frames_dropped
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [10:0]     W_LO    = 11'(OUT_X);
   localparam logic [10:0]     W_HI    = 11'(MAX_W);
   localparam logic [8:0]      H_LO    = 9'(OUT_Y);
   localparam logic [8:0]      H_HI    = 9'(MAX_H);
   localparam logic [12:0]     OUT_PIX = 13'(OUT_X * OUT_Y);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);

   typedef enum logic [1:0] {ARM, FEED, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic            vsync_q, vrise, cfg_ok, accept;
   logic [20:0]     in_cnt, in_cnt_inc, in_total;
   logic [12:0]     out_cnt;
   logic [WD_W-1:0] wd_cnt;
   logic            in_last, out_full, wd_exp;
   logic            drop_evt, set_cfg, set_short, set_to;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign vrise      = vsync_in & ~vsync_q;
   assign cfg_ok     = (cfg_width >= W_LO) && (cfg_width <= W_HI) &&
                       (cfg_height >= H_LO) && (cfg_height <= H_HI);
   assign accept     = (state == ARM) && vrise && cfg_enable && cfg_ok;
   assign in_cnt_inc = in_cnt + 21'(de_in);
   assign in_last    = (in_cnt_inc == in_total);
   assign out_full   = (out_cnt == OUT_PIX);
   assign wd_exp     = (wd_cnt == WD_MAX);
   assign frame_done = (state == DONE);

   always_comb begin
      state_nxt = state;
      drop_evt  = 1'b0;
      set_cfg   = 1'b0;
      set_short = 1'b0;
      set_to    = 1'b0;
      case (state)
         ARM: begin
            if (vrise && cfg_enable) begin
               if (cfg_ok) begin
                  state_nxt = FEED;
               end else begin
                  set_cfg  = 1'b1;
                  drop_evt = 1'b1;
               end
            end
         end
         FEED: begin
            // A vsync that coincides with the last pixel still ends the frame cleanly.
            if (in_last || vrise) state_nxt = DRAIN;
            drop_evt  = vrise;
            set_short = vrise && !in_last;
         end
         DRAIN: begin
            drop_evt = vrise;
            if (out_full) begin
               state_nxt = DONE;
            end else if (wd_exp) begin
               set_to    = 1'b1;
               state_nxt = ARM;
            end
         end
         DONE: begin
            drop_evt  = vrise;
            state_nxt = ARM;
         end
         default: state_nxt = ARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ARM;
         vsync_q         <= 1'b0;
         in_cnt          <= '0;
         out_cnt         <= '0;
         wd_cnt          <= '0;
         busy            <= 1'b0;
         rs_vsync        <= 1'b0;
         rs_de           <= 1'b0;
         rs_pixel        <= '0;
         rs_in_width     <= '0;
         rs_in_height    <= '0;
         err_cfg         <= 1'b0;
         err_short       <= 1'b0;
         err_timeout     <= 1'b0;
         frames_accepted <= '0;
         frames_dropped  <= '0;
      end else begin
         state    <= state_nxt;
         vsync_q  <= vsync_in;
         busy     <= (state == FEED) || (state == DRAIN);
         rs_de    <= de_in && (state == FEED);
         rs_pixel <= (state == FEED) ? pixel_in : 24'd0;
         rs_vsync <= accept || ((state == FEED) && !vrise && vsync_in);

         if (accept) begin
            rs_in_width     <= cfg_width;
            rs_in_height    <= cfg_height;
            frames_accepted <= sat_inc(frames_accepted);
            in_cnt          <= '0;
            out_cnt         <= '0;
         end else begin
            if ((state == FEED) && de_in) in_cnt <= in_cnt_inc;
            if (((state == FEED) || (state == DRAIN)) && rs_de_out && !out_full)
               out_cnt <= out_cnt + 13'd1;
         end

         if (drop_evt) frames_dropped <= sat_inc(frames_dropped);

         // Watchdog only runs while draining; any output pixel re-arms it.
         if ((state != DRAIN) || rs_de_out) wd_cnt <= '0;
         else if (!wd_exp)                  wd_cnt <= wd_cnt + 1'b1;

         if (set_cfg)      err_cfg <= 1'b1;
         else if (err_clr) err_cfg <= 1'b0;
         if (set_short)    err_short <= 1'b1;
         else if (err_clr) err_short <= 1'b0;
         if (set_to)       err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

   // Frame product is registered at admission so FEED compares against a stable total.
   always_ff @(posedge clk) begin
      if (accept) in_total <= 21'(cfg_width) * 21'(cfg_height);
   end

endmodule

// File: tb/tb_resize_frame_ctrl.sv
// Directed bench for resize_frame_ctrl: nominal frame, busy drop, bad config,
// short frame with watchdog expiry, config hold and mid-frame reset.
`timescale 1ns/1ps
module tb_resize_frame_ctrl;

   localparam int TO = 200;

   logic        clk = 1'b0;
   logic        rst, cfg_enable, err_clr, vsync_in, de_in, rs_de_out;
   logic [10:0] cfg_width;
   logic [8:0]  cfg_height;
   logic [23:0] pixel_in;
   logic        rs_vsync, rs_de, busy, frame_done, err_cfg, err_short, err_timeout;
   logic [23:0] rs_pixel;
   logic [10:0] rs_in_width;
   logic [8:0]  rs_in_height;
   logic [15:0] frames_accepted, frames_dropped;

   int checks   = 0;
   int failures = 0;

   resize_frame_ctrl #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_width(cfg_width),
      .cfg_height(cfg_height), .err_clr(err_clr), .vsync_in(vsync_in), .de_in(de_in),
      .pixel_in(pixel_in), .rs_vsync(rs_vsync), .rs_de(rs_de), .rs_pixel(rs_pixel),
      .rs_in_width(rs_in_width), .rs_in_height(rs_in_height), .rs_de_out(rs_de_out),
      .busy(busy), .frame_done(frame_done), .err_cfg(err_cfg), .err_short(err_short),
      .err_timeout(err_timeout), .frames_accepted(frames_accepted),
      .frames_dropped(frames_dropped)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         de_in    = 1'b1;
         pixel_in = 24'(i + 24'h100);
         cyc();
      end
      de_in    = 1'b0;
      pixel_in = '0;
   endtask

   task automatic emit(input int n);
      for (int i = 0; i < n; i++) begin
         rs_de_out = 1'b1;
         cyc();
      end
      rs_de_out = 1'b0;
   endtask

   int  n;
   logic seen;

   initial begin
      rst = 1'b1; cfg_enable = 1'b0; err_clr = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
      rs_de_out = 1'b0; cfg_width = 11'd96; cfg_height = 9'd96; pixel_in = '0;
      cyc(); cyc();
      chk("rst_busy", busy, 0);
      chk("rst_rs_vsync", rs_vsync, 0);
      chk("rst_rs_de", rs_de, 0);
      chk("rst_width", rs_in_width, 0);
      chk("rst_acc", frames_accepted, 0);
      chk("rst_errs", {err_cfg, err_short, err_timeout}, 0);
      rst = 1'b0; cfg_enable = 1'b1;
      cyc();

      // Nominal 96x96 frame
      vsync_in = 1'b1; cyc();
      chk("nom_rs_vsync", rs_vsync, 1);
      chk("nom_width", rs_in_width, 96);
      chk("nom_height", rs_in_height, 96);
      chk("nom_acc", frames_accepted, 1);
      vsync_in = 1'b0; cyc();
      chk("nom_busy", busy, 1);
      de_in = 1'b1; pixel_in = 24'hABCDEF; cyc();
      chk("nom_rs_de", rs_de, 1);
      chk("nom_rs_pixel", rs_pixel, 24'hABCDEF);
      feed(9215);
      emit(4096);
      chk("nom_no_done_early", frame_done, 0);
      cyc();
      chk("nom_done", frame_done, 1);
      chk("nom_busy_at_done", busy, 1);
      cyc();
      chk("nom_done_pulse", frame_done, 0);
      chk("nom_busy_fall", busy, 0);
      chk("nom_dropped", frames_dropped, 0);

      // Vsync while draining is dropped, frame still completes
      vsync_in = 1'b1; cyc();
      chk("drop_acc2", frames_accepted, 2);
      vsync_in = 1'b0; cyc();
      feed(9216);
      emit(3996);
      vsync_in = 1'b1; cyc();
      chk("drop_rs_vsync", rs_vsync, 0);
      chk("drop_count", frames_dropped, 1);
      vsync_in = 1'b0; cyc();
      chk("drop_rs_vsync2", rs_vsync, 0);
      emit(100);
      cyc();
      chk("drop_done", frame_done, 1);
      cyc();
      chk("drop_acc_final", frames_accepted, 2);

      // Invalid configuration
      cfg_width = 11'd32;
      vsync_in = 1'b1; cyc();
      chk("cfg_err", err_cfg, 1);
      chk("cfg_dropped", frames_dropped, 2);
      chk("cfg_rs_vsync", rs_vsync, 0);
      vsync_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         de_in = 1'b1; cyc(); seen |= rs_de;
      end
      de_in = 1'b0;
      chk("cfg_no_rs_de", seen, 0);
      chk("cfg_not_busy", busy, 0);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      chk("cfg_err_clr", err_cfg, 0);

      // Short frame then watchdog expiry
      cfg_width = 11'd96;
      vsync_in = 1'b1; cyc();
      chk("short_acc", frames_accepted, 3);
      vsync_in = 1'b0; cyc();
      feed(5000);
      vsync_in = 1'b1; cyc();
      chk("short_err", err_short, 1);
      chk("short_dropped", frames_dropped, 3);
      chk("short_rs_vsync", rs_vsync, 0);
      vsync_in = 1'b0;
      n = 0; seen = 1'b0;
      while (!err_timeout && n < 2 * TO) begin
         cyc(); n++; seen |= frame_done;
      end
      chk("short_timeout", err_timeout, 1);
      chk("short_timeout_cycles", n, TO + 1);
      chk("short_busy_in_drain", busy, 1);
      cyc();
      chk("short_back_to_arm", busy, 0);
      chk("short_no_done", seen, 0);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      chk("short_errs_clr", {err_short, err_timeout}, 0);

      // Config change mid-frame is held off until next admission
      vsync_in = 1'b1; cyc();
      chk("hold_acc", frames_accepted, 4);
      vsync_in = 1'b0; cyc();
      feed(100);
      cfg_width = 11'd128;
      feed(9116);
      chk("hold_width_mid", rs_in_width, 96);
      emit(4096);
      cyc();
      chk("hold_done", frame_done, 1);
      cyc();
      chk("hold_width_after", rs_in_width, 96);
      vsync_in = 1'b1; cyc();
      chk("hold_width_new", rs_in_width, 128);
      chk("hold_acc2", frames_accepted, 5);
      vsync_in = 1'b0; cyc();

      // Reset in the middle of a frame
      feed(2999);
      de_in = 1'b1; rst = 1'b1; cyc(); rst = 1'b0;
      chk("mrst_rs_de", rs_de, 0);
      chk("mrst_acc", frames_accepted, 0);
      chk("mrst_dropped", frames_dropped, 0);
      chk("mrst_width", rs_in_width, 0);
      chk("mrst_busy", busy, 0);
      cyc();
      chk("mrst_rs_de_next", rs_de, 0);
      de_in = 1'b0;
      vsync_in = 1'b1; cyc();
      chk("mrst_readmit_acc", frames_accepted, 1);
      chk("mrst_readmit_width", rs_in_width, 128);
      chk("mrst_readmit_height", rs_in_height, 96);
      chk("mrst_readmit_vsync", rs_vsync, 1);
      vsync_in = 1'b0; cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
